// File: rtl/gam_pattern_feeder_if.sv
// Feeder <-> GAM memory layer handshake: node/query vector, class tag,
// READY/WAIT back-pressure and the learning/recall mode flags.
interface gam_feeder_if #(
  parameter int unsigned NODE_W  = 32,
  parameter int unsigned CLASS_W = 8
);
  logic [NODE_W-1:0]  x;
  logic [CLASS_W-1:0] c;
  logic               ready_wait;
  logic               learning_done;
  logic               learning_recall;

  modport master (
    output x, c, learning_done, learning_recall,
    input  ready_wait
  );

  modport slave (
    input  x, c, learning_done, learning_recall,
    output ready_wait
  );
endinterface

// File: rtl/gam_pattern_feeder.sv
// On-chip learning-pattern sequencer for the GAM memory layer: streams a
// per-class node table, then forwards recall queries. Optional watchdog: GAM_FEEDER_TIMEOUT_EN.
module gam_pattern_feeder #(
  parameter int unsigned NODE_W      = 32,
  parameter int unsigned CLASS_COUNT = 4,
  parameter int unsigned NODE_COUNT  = 16,
  parameter int unsigned CLASS_W     = 8,
  parameter int unsigned NODE_IDX_W  = 5,
  parameter int unsigned TIMEOUT     = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  gam_feeder_if.master          mem,
  input  logic                  wr_en,
  input  logic [CLASS_W-1:0]    wr_class,
  input  logic [NODE_IDX_W-1:0] wr_node,
  input  logic [NODE_W-1:0]     wr_data,
  input  logic [CLASS_W-1:0]    num_classes,
  input  logic [NODE_IDX_W-1:0] num_nodes,
  input  logic                  start,
  input  logic                  recall_valid,
  input  logic [NODE_W-1:0]     recall_query,
  output logic                  busy,
  output logic                  timeout_err
);

  localparam int unsigned CI_W = (CLASS_COUNT > 1) ? $clog2(CLASS_COUNT) : 1;
  localparam int unsigned NI_W = (NODE_COUNT > 1) ? $clog2(NODE_COUNT) : 1;
  localparam logic [CLASS_W-1:0]    CLASS_MAX = CLASS_W'(CLASS_COUNT);
  localparam logic [NODE_IDX_W-1:0] NODE_MAX  = NODE_IDX_W'(NODE_COUNT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_HOLD,
    S_DONE,
    S_RECALL
  } state_t;

  state_t state_q, state_d;

  logic [NODE_W-1:0]     x_q, x_d;
  logic [CLASS_W-1:0]    c_q, c_d;
  logic                  done_q, done_d;
  logic                  recall_q, recall_d;
  logic                  busy_q, busy_d;
  logic [CLASS_W-1:0]    cls_q, cls_d, ncls_q, ncls_d;
  logic [NODE_IDX_W-1:0] node_q, node_d, nnode_q, nnode_d;

  logic [NODE_W-1:0] table_q [CLASS_COUNT][NODE_COUNT];

  logic            table_open;
  logic            wr_ok;
  logic            start_ok;
  logic [CI_W-1:0] wr_ci, rd_ci;
  logic [NI_W-1:0] wr_ni, rd_ni;

  // Table is only writable while no feed is in flight; out-of-range indices drop.
  assign table_open = (state_q == S_IDLE) || (state_q == S_RECALL);
  assign wr_ok = wr_en && table_open &&
                 (wr_class != '0) && (wr_class <= CLASS_MAX) &&
                 (wr_node  != '0) && (wr_node  <= NODE_MAX);
  assign start_ok = start &&
                    (num_classes != '0) && (num_classes <= CLASS_MAX) &&
                    (num_nodes   != '0) && (num_nodes   <= NODE_MAX);

  assign wr_ci = CI_W'(wr_class - CLASS_W'(1));
  assign wr_ni = NI_W'(wr_node - NODE_IDX_W'(1));
  assign rd_ci = CI_W'(cls_q - CLASS_W'(1));
  assign rd_ni = NI_W'(node_q - NODE_IDX_W'(1));

  // Pattern storage survives reset so a reset feed can be restarted as-is.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      table_q[wr_ci][wr_ni] <= wr_data;
    end
  end

`ifdef GAM_FEEDER_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            tmo_q, tmo_d;
`endif

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    c_d      = c_q;
    done_d   = done_q;
    recall_d = recall_q;
    cls_d    = cls_q;
    node_d   = node_q;
    ncls_d   = ncls_q;
    nnode_d  = nnode_q;
`ifdef GAM_FEEDER_TIMEOUT_EN
    wd_d  = '0;
    tmo_d = tmo_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          state_d = S_ISSUE;
          ncls_d  = num_classes;
          nnode_d = num_nodes;
          cls_d   = CLASS_W'(1);
          node_d  = NODE_IDX_W'(1);
`ifdef GAM_FEEDER_TIMEOUT_EN
          tmo_d = 1'b0;
`endif
        end
      end
      S_ISSUE: begin
        if (mem.ready_wait) begin
          x_d     = table_q[rd_ci][rd_ni];
          c_d     = cls_q;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        // WAIT from the memory means the current node was taken.
        if (!mem.ready_wait) begin
          if (node_q == nnode_q) begin
            node_d = NODE_IDX_W'(1);
            if (cls_q == ncls_q) begin
              state_d = S_DONE;
            end else begin
              cls_d   = cls_q + CLASS_W'(1);
              state_d = S_ISSUE;
            end
          end else begin
            node_d  = node_q + NODE_IDX_W'(1);
            state_d = S_ISSUE;
          end
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        c_d     = '0;
        state_d = S_RECALL;
      end
      S_RECALL: begin
        recall_d = 1'b1;
        if (recall_valid) begin
          x_d = recall_query;
        end
        if (start_ok) begin
          state_d  = S_ISSUE;
          done_d   = 1'b0;
          recall_d = 1'b0;
          ncls_d   = num_classes;
          nnode_d  = num_nodes;
          cls_d    = CLASS_W'(1);
          node_d   = NODE_IDX_W'(1);
`ifdef GAM_FEEDER_TIMEOUT_EN
          tmo_d = 1'b0;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef GAM_FEEDER_TIMEOUT_EN
    // Dwell counter for ISSUE/HOLD; any state change restarts it.
    if (((state_q == S_ISSUE) || (state_q == S_HOLD)) && (state_d == state_q)) begin
      if (wd_q == WD_W'(TIMEOUT - 1)) begin
        state_d = S_IDLE;
        c_d     = '0;
        tmo_d   = 1'b1;
      end else begin
        wd_d = wd_q + WD_W'(1);
      end
    end
`endif

    busy_d = (state_d == S_ISSUE) || (state_d == S_HOLD);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      x_q      <= '0;
      c_q      <= '0;
      done_q   <= 1'b0;
      recall_q <= 1'b0;
      busy_q   <= 1'b0;
      cls_q    <= '0;
      node_q   <= '0;
      ncls_q   <= '0;
      nnode_q  <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      c_q      <= c_d;
      done_q   <= done_d;
      recall_q <= recall_d;
      busy_q   <= busy_d;
      cls_q    <= cls_d;
      node_q   <= node_d;
      ncls_q   <= ncls_d;
      nnode_q  <= nnode_d;
    end
  end

`ifdef GAM_FEEDER_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_q  <= '0;
      tmo_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      tmo_q <= tmo_d;
    end
  end

  assign timeout_err = tmo_q;
`else
  // Without the watchdog the feeder waits on the memory indefinitely.
  logic timeout_unused;
  assign timeout_unused = (TIMEOUT != 0);
  assign timeout_err    = 1'b0;
`endif

  assign mem.x               = x_q;
  assign mem.c               = c_q;
  assign mem.learning_done   = done_q;
  assign mem.learning_recall = recall_q;
  assign busy                = busy_q;

endmodule

// File: tb/tb_gam_pattern_feeder.sv
// Scoreboard bench for gam_pattern_feeder: a reference pattern table drives
// expected {c,x} pairs; a READY/WAIT memory model captures what the feeder issues.
module tb_gam_pattern_feeder;
  localparam int unsigned NODE_W      = 32;
  localparam int unsigned CLASS_COUNT = 4;
  localparam int unsigned NODE_COUNT  = 16;
  localparam int unsigned CLASS_W     = 8;
  localparam int unsigned NODE_IDX_W  = 5;
  localparam int unsigned TIMEOUT     = 16;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  wr_en;
  logic [CLASS_W-1:0]    wr_class;
  logic [NODE_IDX_W-1:0] wr_node;
  logic [NODE_W-1:0]     wr_data;
  logic [CLASS_W-1:0]    num_classes;
  logic [NODE_IDX_W-1:0] num_nodes;
  logic                  start;
  logic                  recall_valid;
  logic [NODE_W-1:0]     recall_query;
  logic                  busy;
  logic                  timeout_err;

  gam_feeder_if #(.NODE_W(NODE_W), .CLASS_W(CLASS_W)) mem ();

  gam_pattern_feeder #(
    .NODE_W(NODE_W), .CLASS_COUNT(CLASS_COUNT), .NODE_COUNT(NODE_COUNT),
    .CLASS_W(CLASS_W), .NODE_IDX_W(NODE_IDX_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .mem(mem),
    .wr_en(wr_en), .wr_class(wr_class), .wr_node(wr_node), .wr_data(wr_data),
    .num_classes(num_classes), .num_nodes(num_nodes), .start(start),
    .recall_valid(recall_valid), .recall_query(recall_query),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [NODE_W-1:0] tbl [1:CLASS_COUNT][1:NODE_COUNT];
  logic [CLASS_W+NODE_W-1:0] exp_q[$];
  logic [CLASS_W+NODE_W-1:0] obs_q[$];

  int   done_rises = 0;
  logic done_prev  = 1'b0;
  always @(negedge clk) begin
    done_prev <= mem.learning_done;
    if (mem.learning_done && !done_prev) done_rises <= done_rises + 1;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "global timeout");
  end

  task automatic wr(input int cc, input int nn, input logic [NODE_W-1:0] d, input bit upd);
    @(negedge clk);
    wr_en = 1'b1; wr_class = CLASS_W'(cc); wr_node = NODE_IDX_W'(nn); wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    if (upd) tbl[cc][nn] = d;
  endtask

  task automatic start_feed(input int nc, input int nn);
    @(negedge clk);
    mem.ready_wait = 1'b0;
    num_classes = CLASS_W'(nc); num_nodes = NODE_IDX_W'(nn); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic push_feed(input int nc, input int nn);
    for (int ci = 1; ci <= nc; ci++)
      for (int ni = 1; ni <= nn; ni++)
        exp_q.push_back({CLASS_W'(ci), tbl[ci][ni]});
  endtask

  // Memory model: READY until a new x appears, WAIT two cycles later for one cycle.
  task automatic mem_serve(input int max_nodes, input int budget, output bit expired);
    logic [NODE_W-1:0]  px;
    logic [CLASS_W-1:0] pc;
    int got;
    px = mem.x; pc = mem.c; got = 0; expired = 1'b1;
    mem.ready_wait = 1'b1;
    for (int cyc = 0; cyc < budget; cyc++) begin
      @(posedge clk); #1;
      if (mem.learning_done) begin expired = 1'b0; break; end
      if (mem.c != '0 && (mem.x != px || mem.c != pc)) begin
        obs_q.push_back({mem.c, mem.x});
        px = mem.x; pc = mem.c; got++;
        if (got == max_nodes) begin expired = 1'b0; break; end
        repeat (2) @(posedge clk);
        #1 mem.ready_wait = 1'b0;
        @(posedge clk);
        #1 mem.ready_wait = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; wr_en = 1'b0; wr_class = '0; wr_node = '0; wr_data = '0;
    num_classes = '0; num_nodes = '0; start = 1'b0; recall_valid = 1'b0;
    recall_query = '0; mem.ready_wait = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (mem.x !== '0) begin failures++; $display("FAIL reset_x got=%h want=0", mem.x); end
    checks++; if (mem.c !== '0) begin failures++; $display("FAIL reset_c got=%h want=0", mem.c); end
    checks++; if (mem.learning_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", mem.learning_done); end
    checks++; if (mem.learning_recall !== 1'b0) begin failures++; $display("FAIL reset_recall got=%b want=0", mem.learning_recall); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%b want=0", timeout_err); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_single_class();
    logic [NODE_W-1:0] vals [8];
    logic [CLASS_W+NODE_W-1:0] e, o;
    bit expired;
    int rises0;
    vals = '{32'h3, 32'h400, 32'h70005, 32'h101, 32'h0c0b0a09, 32'h604, 32'h60002, 32'h202};
    for (int i = 0; i < 8; i++) wr(1, i + 1, vals[i], 1'b1);
    rises0 = done_rises;
    push_feed(1, 8);
    start_feed(1, 8);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy got=%b want=1", busy); end
    mem_serve(100, 400, expired);
    checks++; if (expired) begin failures++; $display("FAIL single_done_wait got=expired want=learning_done"); end
    checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL single_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '0;
      checks++; if (o !== e) begin failures++; $display("FAIL single_node got=%h want=%h", o, e); end
    end
    obs_q.delete();
    checks++; if (mem.c !== '0) begin failures++; $display("FAIL single_done_c got=%h want=0", mem.c); end
    checks++; if (mem.learning_recall !== 1'b0) begin failures++; $display("FAIL single_recall_early got=%b want=0", mem.learning_recall); end
    @(posedge clk); #1;
    checks++; if (mem.learning_recall !== 1'b1) begin failures++; $display("FAIL single_recall got=%b want=1", mem.learning_recall); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_end got=%b want=0", busy); end
    @(negedge clk);
    checks++; if (done_rises - rises0 != 1) begin failures++; $display("FAIL single_done_rises got=%0d want=1", done_rises - rises0); end
  endtask

  task automatic test_two_class();
    logic [CLASS_W+NODE_W-1:0] e, o;
    bit expired;
    int rises0;
    wr(1, 1, 32'h11110001, 1'b1);
    wr(1, 2, 32'h11110002, 1'b1);
    wr(2, 1, 32'h22220001, 1'b1);
    wr(2, 2, 32'h22220002, 1'b1);
    checks++; if (mem.learning_done !== 1'b1) begin failures++; $display("FAIL two_done_held got=%b want=1", mem.learning_done); end
    rises0 = done_rises;
    push_feed(2, 2);
    start_feed(2, 2);
    checks++; if (mem.learning_done !== 1'b0) begin failures++; $display("FAIL two_done_clear got=%b want=0", mem.learning_done); end
    checks++; if (mem.learning_recall !== 1'b0) begin failures++; $display("FAIL two_recall_clear got=%b want=0", mem.learning_recall); end
    mem_serve(100, 400, expired);
    checks++; if (expired) begin failures++; $display("FAIL two_done_wait got=expired want=learning_done"); end
    checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL two_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '0;
      checks++; if (o !== e) begin failures++; $display("FAIL two_node got=%h want=%h", o, e); end
    end
    obs_q.delete();
    repeat (4) @(negedge clk);
    checks++; if (done_rises - rises0 != 1) begin failures++; $display("FAIL two_done_rises got=%0d want=1", done_rises - rises0); end
  endtask

  task automatic test_recall();
    logic [NODE_W-1:0] q [2];
    q = '{32'h070005, 32'hdeadbeef};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      recall_valid = 1'b1; recall_query = q[i];
      @(posedge clk); #1;
      recall_valid = 1'b0;
      checks++; if (mem.x !== q[i]) begin failures++; $display("FAIL recall_x got=%h want=%h", mem.x, q[i]); end
      checks++; if (mem.c !== '0) begin failures++; $display("FAIL recall_c got=%h want=0", mem.c); end
      checks++; if (mem.learning_recall !== 1'b1) begin failures++; $display("FAIL recall_mode got=%b want=1", mem.learning_recall); end
    end
  endtask

  task automatic test_busy_write();
    logic [CLASS_W+NODE_W-1:0] e, o;
    bit expired;
    push_feed(2, 2);
    start_feed(2, 2);
    wr(1, 1, 32'hbad0bad0, 1'b0);
    mem_serve(100, 400, expired);
    checks++; if (expired) begin failures++; $display("FAIL busywr_done_wait got=expired want=learning_done"); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '0;
      checks++; if (o !== e) begin failures++; $display("FAIL busywr_node got=%h want=%h", o, e); end
    end
    obs_q.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_feed();
    logic [CLASS_W+NODE_W-1:0] e, o;
    bit expired;
    for (int i = 3; i <= 8; i++) wr(1, i, 32'h33000000 + i, 1'b1);
    push_feed(1, 3);
    start_feed(1, 8);
    mem_serve(3, 200, expired);
    checks++; if (expired) begin failures++; $display("FAIL mid_reach_node3 got=expired want=node3"); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '0;
      checks++; if (o !== e) begin failures++; $display("FAIL mid_node got=%h want=%h", o, e); end
    end
    obs_q.delete();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (mem.x !== '0) begin failures++; $display("FAIL mid_reset_x got=%h want=0", mem.x); end
    checks++; if (mem.c !== '0) begin failures++; $display("FAIL mid_reset_c got=%h want=0", mem.c); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_reset_busy got=%b want=0", busy); end
    @(negedge clk);
    reset = 1'b0;
    push_feed(1, 8);
    start_feed(1, 8);
    mem_serve(100, 400, expired);
    checks++; if (expired) begin failures++; $display("FAIL mid_restart_wait got=expired want=learning_done"); end
    checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL mid_restart_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '0;
      checks++; if (o !== e) begin failures++; $display("FAIL mid_restart_node got=%h want=%h", o, e); end
    end
    obs_q.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_illegal_start();
    int bad_nc [4];
    int bad_nn [4];
    bad_nc = '{1, 5, 0, 1};
    bad_nn = '{0, 2, 2, 17};
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      start_feed(bad_nc[i], bad_nn[i]);
      repeat (2) @(posedge clk);
      #1;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL illegal_busy case=%0d got=%b want=0", i, busy); end
      checks++; if (mem.c !== '0) begin failures++; $display("FAIL illegal_c case=%0d got=%h want=0", i, mem.c); end
    end
    wr(5, 2, 32'hee000005, 1'b0);
    wr(2, 17, 32'hee000011, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [CLASS_W+NODE_W-1:0] e, o;
    bit expired;
    @(negedge clk);
    mem.ready_wait = 1'b0;
    wr_en = 1'b1; wr_class = CLASS_W'(1); wr_node = NODE_IDX_W'(1); wr_data = 32'h5a5a0001;
    num_classes = CLASS_W'(2); num_nodes = NODE_IDX_W'(2); start = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; start = 1'b0;
    tbl[1][1] = 32'h5a5a0001;
    push_feed(2, 2);
    mem_serve(100, 400, expired);
    checks++; if (expired) begin failures++; $display("FAIL b2b_done_wait got=expired want=learning_done"); end
    checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL b2b_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '0;
      checks++; if (o !== e) begin failures++; $display("FAIL b2b_node got=%h want=%h", o, e); end
    end
    obs_q.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_watchdog();
    start_feed(1, 2);
    repeat (TIMEOUT - 1) @(posedge clk);
    #1;
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL wd_early got=%b want=0", timeout_err); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL wd_busy_early got=%b want=1", busy); end
    @(posedge clk); #1;
`ifdef GAM_FEEDER_TIMEOUT_EN
    checks++; if (timeout_err !== 1'b1) begin failures++; $display("FAIL wd_fire got=%b want=1", timeout_err); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL wd_idle_busy got=%b want=0", busy); end
    start_feed(1, 2);
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL wd_clear_on_start got=%b want=0", timeout_err); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL wd_restart_busy got=%b want=1", busy); end
`else
    repeat (8) @(posedge clk);
    #1;
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL wd_disabled_err got=%b want=0", timeout_err); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL wd_disabled_busy got=%b want=1", busy); end
`endif
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask

  initial begin
    for (int ci = 1; ci <= CLASS_COUNT; ci++)
      for (int ni = 1; ni <= NODE_COUNT; ni++)
        tbl[ci][ni] = '0;
    test_reset();
    test_single_class();
    test_two_class();
    test_recall();
    test_busy_write();
    test_reset_mid_feed();
    test_illegal_start();
    test_back_to_back();
    test_watchdog();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
